// File: rtl/cp0_timer_intc.sv
// cp0_timer_intc: CP0 Count/Compare timer, Cause.IP state and interrupt resolution.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   hw_int[N_HW-1:0]    asynchronous level-sensitive hardware interrupt lines
//   wr_valid/id/data    CP0 MTC0 write port (Count=9, Compare=11, Cause=13)
//   st_ie/exl/erl/im    Status fields forwarded from the CP0 register file
//   count, compare      Count and Compare registers
//   ip                  Cause.IP view (software, synchronised hardware, timer)
//   ti                  Cause.TI, sticky timer interrupt
//   int_req, int_code   registered interrupt request and highest pending IP index
module cp0_timer_intc #(
    parameter int unsigned COUNT_DIV   = 2,
    parameter int unsigned N_HW        = 6,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMER_IP    = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_HW-1:0] hw_int,
    input  logic            wr_valid,
    input  logic [4:0]      wr_id,
    input  logic [31:0]     wr_data,
    input  logic            st_ie,
    input  logic            st_exl,
    input  logic            st_erl,
    input  logic [7:0]      st_im,
    output logic [31:0]     count,
    output logic [31:0]     compare,
    output logic [7:0]      ip,
    output logic            ti,
    output logic            int_req,
    output logic [2:0]      int_code
);

    localparam int unsigned PRE_W    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    // ip_q holds the final synchroniser stage, so the chain itself has one fewer flop
    localparam int unsigned SYNC_PRE = (SYNC_STAGES > 1) ? SYNC_STAGES - 1 : 1;
    localparam logic [4:0]  ID_COUNT   = 5'd9;
    localparam logic [4:0]  ID_COMPARE = 5'd11;
    localparam logic [4:0]  ID_CAUSE   = 5'd13;

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [31:0]      count_q, count_d;
    logic [31:0]      compare_q, compare_d;
    logic             ti_q, ti_d;
    logic [7:0]       ip_q, ip_d;
    logic             int_req_q, int_req_d;
    logic [2:0]       int_code_q, int_code_d;
    logic [N_HW-1:0]  sync_q [SYNC_PRE];
    logic [N_HW-1:0]  sync_d [SYNC_PRE];

    logic             tick_c;
    logic             wr_count_c;
    logic             wr_compare_c;
    logic             wr_cause_c;
    logic [31:0]      count_inc_c;
    logic [N_HW-1:0]  hw_last_c;
    logic [7:0]       pend_c;

    // Decoded write strobes and prescaler tick
    always_comb begin
        wr_count_c   = wr_valid && (wr_id == ID_COUNT);
        wr_compare_c = wr_valid && (wr_id == ID_COMPARE);
        wr_cause_c   = wr_valid && (wr_id == ID_CAUSE);
        tick_c       = (pre_q == PRE_W'(COUNT_DIV - 1));
        count_inc_c  = count_q + 32'd1;
    end

    // Prescaler, Count, Compare and the sticky timer flag
    always_comb begin
        pre_d     = pre_q;
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;

        if (wr_count_c || tick_c) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + PRE_W'(1);
        end

        // A Count write overrides the tick and can never raise ti
        if (wr_count_c) begin
            count_d = wr_data;
        end else if (tick_c) begin
            count_d = count_inc_c;
            if (count_inc_c == compare_q) begin
                ti_d = 1'b1;
            end
        end

        // Compare write clears ti, winning over a same-cycle match
        if (wr_compare_c) begin
            compare_d = wr_data;
            ti_d      = 1'b0;
        end
    end

    // Hardware line synchroniser chain (final stage lives in ip_q)
    always_comb begin
        for (int s = 0; s < int'(SYNC_PRE); s++) begin
            sync_d[s] = sync_q[s];
        end
        sync_d[0] = hw_int;
        for (int s = 1; s < int'(SYNC_PRE); s++) begin
            sync_d[s] = sync_q[s-1];
        end
        hw_last_c = (SYNC_STAGES > 1) ? sync_q[SYNC_PRE-1] : hw_int;
    end

    // Next Cause.IP: software bits held, hardware bits level, timer ORed in
    always_comb begin
        ip_d = 8'h00;
        ip_d[1:0] = wr_cause_c ? wr_data[9:8] : ip_q[1:0];
        for (int i = 0; i < int'(N_HW); i++) begin
            ip_d[2+i] = hw_last_c[i];
        end
        ip_d[TIMER_IP] = ip_d[TIMER_IP] | ti_d;
    end

    // Masked pending resolution, one cycle behind ip and Status
    always_comb begin
        pend_c     = ip_q & st_im;
        int_req_d  = st_ie && !st_exl && !st_erl && (pend_c != 8'h00);
        int_code_d = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pend_c[i]) begin
                int_code_d = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q      <= '0;
            count_q    <= 32'h0;
            compare_q  <= 32'h0;
            ti_q       <= 1'b0;
            ip_q       <= 8'h00;
            int_req_q  <= 1'b0;
            int_code_q <= 3'd0;
            for (int s = 0; s < int'(SYNC_PRE); s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            pre_q      <= pre_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            ti_q       <= ti_d;
            ip_q       <= ip_d;
            int_req_q  <= int_req_d;
            int_code_q <= int_code_d;
            for (int s = 0; s < int'(SYNC_PRE); s++) begin
                sync_q[s] <= sync_d[s];
            end
        end
    end

    assign count    = count_q;
    assign compare  = compare_q;
    assign ip       = ip_q;
    assign ti       = ti_q;
    assign int_req  = int_req_q;
    assign int_code = int_code_q;

endmodule
